// File: rtl/demux_pkg.sv
// demux_pkg: shared types and helpers for the stream demultiplexer.
//   beat_t      default-width data beat
//   lane_cnt_t  default-width delivered-beat counter
//   sel_w()     index width for n items (minimum 1 bit)
package demux_pkg;

  localparam int unsigned BeatWidth    = 8;
  localparam int unsigned LaneCntWidth = 16;

  typedef logic [BeatWidth-1:0]    beat_t;
  typedef logic [LaneCntWidth-1:0] lane_cnt_t;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// demux_lane: one output lane of the demultiplexer. A DEPTH-entry synchronous FIFO with
// wrap-around pointers and an occupancy count, plus a counter of completed pops.
// Ports:
//   clk, rst_n     clock, synchronous active-high reset
//   push, wdata    write request and data (ignored while full)
//   full           lane holds DEPTH entries
//   pop            read request (ignored while empty)
//   rdata, empty   head entry and empty flag
//   cnt            number of completed pops, wraps at 2^CNT_W
module demux_lane
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned PtrW = sel_w(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en, pop_en;

  // Pointers wrap explicitly so non-power-of-two depths would also work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (occ_q == OccW'(DEPTH));
  assign empty   = (occ_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d    = cnt_q + CNT_W'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    unique case ({push_en, pop_en})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      // Cleared so the head output reads 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      if (push_en) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/demux1to4_stream.sv
// demux1to4_stream: registered 1-to-N stream demultiplexer. Each accepted input beat is
// written into the FIFO of lane in_sel; each lane drains independently.
// Ports:
//   clk, rst_n            clock, synchronous active-high reset (asserted = 1)
//   in_valid, in_ready    input handshake; in_ready depends only on reset and lane in_sel
//   in_data, in_sel       input beat and destination lane
//   out_valid, out_ready  per-lane output handshake
//   out_data              per-lane head entry
//   out_cnt               per-lane count of completed output handshakes
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [sel_w(N_OUT)-1:0]       in_sel,
  output logic [N_OUT-1:0]              out_valid,
  input  logic [N_OUT-1:0]              out_ready,
  output logic [N_OUT-1:0][WIDTH-1:0]   out_data,
  output logic [N_OUT-1:0][CNT_W-1:0]   out_cnt
);

  localparam int unsigned SelW = sel_w(N_OUT);

  logic [N_OUT-1:0] push;
  logic [N_OUT-1:0] pop;
  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] empty;

  // A full target lane refuses input even if it pops this cycle, keeping in_ready
  // independent of out_ready.
  assign in_ready = !rst_n && !full[in_sel];
  assign pop      = out_valid & out_ready;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    assign push[k]      = in_valid && in_ready && (in_sel == SelW'(k));
    assign out_valid[k] = !empty[k];

    demux_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .wdata (in_data),
      .full  (full[k]),
      .pop   (pop[k]),
      .rdata (out_data[k]),
      .empty (empty[k]),
      .cnt   (out_cnt[k])
    );
  end

endmodule

// File: tb/tb_demux1to4_stream.sv
module tb_demux1to4_stream;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic [1:0]      in_sel;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [3:0][7:0] out_data;
  logic [3:0][3:0] out_cnt;

  int checks = 0;
  int errors = 0;

  demux1to4_stream #(
    .WIDTH (8),
    .N_OUT (4),
    .DEPTH (2),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    tick();
    rst_n = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77; out_ready = 4'h0;
    tick();  // 0x77 into lane 0
    tick();  // 0x77 again into lane 0, lane now full
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_0: got %b expected 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_1: got %b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 4'h0) begin
      errors++; $display("FAIL reset_out_valid: got %h expected 0", out_valid);
    end
    checks++;
    if (out_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_out_cnt: got %h expected 0", out_cnt);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_2: got %b expected 0", in_ready);
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 4'h0) begin
      errors++; $display("FAIL reset_release_valid: got %h expected 0", out_valid);
    end
  endtask

  task automatic test_routing();
    logic [7:0] exp_data;
    do_reset();
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      exp_data = 8'(8'h11 * (i + 1));
      in_valid = 1'b1; in_sel = 2'(i); in_data = exp_data;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL route_ready lane %0d: got %b expected 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 4'(1 << i)) begin
        errors++; $display("FAIL route_valid lane %0d: got %b expected %b", i, out_valid,
                           4'(1 << i));
      end
      checks++;
      if (out_data[i] !== exp_data) begin
        errors++; $display("FAIL route_data lane %0d: got %h expected %h", i, out_data[i],
                           exp_data);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'h0) begin
      errors++; $display("FAIL route_drained: got %b expected 0000", out_valid);
    end
    checks++;
    if (out_cnt !== 16'h1111) begin
      errors++; $display("FAIL route_cnt: got %h expected 1111", out_cnt);
    end
  endtask

  task automatic test_lane_full();
    do_reset();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_a0: got %b expected 1", in_ready);
    end
    tick();
    in_data = 8'hA1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_a1: got %b expected 1", in_ready);
    end
    tick();
    in_data = 8'hA2;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_a2: got %b expected 0", in_ready);
    end
    tick();
    checks++;
    if (out_data[2] !== 8'hA0 || out_valid[2] !== 1'b1) begin
      errors++; $display("FAIL full_head_held: got v=%b d=%h expected v=1 d=a0",
                         out_valid[2], out_data[2]);
    end
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_while_pop: got %b expected 0", in_ready);
    end
    tick();  // A0 pops
    checks++;
    if (out_data[2] !== 8'hA1) begin
      errors++; $display("FAIL full_second_head: got %h expected a1", out_data[2]);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_after_pop: got %b expected 1", in_ready);
    end
    tick();  // A1 pops, A2 pushed
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data[2] !== 8'hA2 || out_valid[2] !== 1'b1) begin
      errors++; $display("FAIL full_third_head: got v=%b d=%h expected v=1 d=a2",
                         out_valid[2], out_data[2]);
    end
    tick();
    checks++;
    if (out_valid[2] !== 1'b0 || out_cnt[2] !== 4'd3) begin
      errors++; $display("FAIL full_drain: got v=%b cnt=%0d expected v=0 cnt=3",
                         out_valid[2], out_cnt[2]);
    end
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C;
    tick();
    out_ready = 4'b0010; in_data = 8'h5A;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data[1] !== 8'h3C) begin
      errors++; $display("FAIL simul_pre: got rdy=%b d=%h expected rdy=1 d=3c",
                         in_ready, out_data[1]);
    end
    tick();
    in_valid = 1'b0; out_ready = 4'h0;
    #1;
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h5A) begin
      errors++; $display("FAIL simul_head: got v=%b d=%h expected v=1 d=5a",
                         out_valid[1], out_data[1]);
    end
    out_ready = 4'b0010;
    tick();
    checks++;
    if (out_valid[1] !== 1'b0) begin
      errors++; $display("FAIL simul_count_one: got v=%b expected 0", out_valid[1]);
    end
    checks++;
    if (out_cnt[1] !== 4'd2) begin
      errors++; $display("FAIL simul_cnt: got %0d expected 2", out_cnt[1]);
    end
  endtask

  task automatic test_head_of_line();
    do_reset();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hB0;
    tick();
    in_data = 8'hB1;
    tick();
    in_data = 8'hB2;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL hol_stall %0d: got %b expected 0", i, in_ready);
      end
      tick();
    end
    checks++;
    if (out_valid[3] !== 1'b0) begin
      errors++; $display("FAIL hol_lane3_idle: got %b expected 0", out_valid[3]);
    end
    out_ready = 4'b0001;
    tick();  // B0 pops
    out_ready = 4'h0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data[0] !== 8'hB1) begin
      errors++; $display("FAIL hol_unblock: got rdy=%b d=%h expected rdy=1 d=b1",
                         in_ready, out_data[0]);
    end
    tick();  // B2 accepted
    in_sel = 2'd3; in_data = 8'hC3;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid[3] !== 1'b0) begin
      errors++; $display("FAIL hol_lane3_ready: got rdy=%b v3=%b expected rdy=1 v3=0",
                         in_ready, out_valid[3]);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b1001 || out_data[3] !== 8'hC3) begin
      errors++; $display("FAIL hol_lane3_data: got v=%b d=%h expected v=1001 d=c3",
                         out_valid, out_data[3]);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready = 4'b1000;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL wrap_ready beat %0d: got %b expected 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_cnt[3] !== 4'd0 || out_data[3] !== 8'd16) begin
      errors++; $display("FAIL wrap_at_16: got cnt=%0d d=%0d expected cnt=0 d=16",
                         out_cnt[3], out_data[3]);
    end
    tick();
    checks++;
    if (out_cnt[3] !== 4'd1 || out_valid[3] !== 1'b0) begin
      errors++; $display("FAIL wrap_at_17: got cnt=%0d v=%b expected cnt=1 v=0",
                         out_cnt[3], out_valid[3]);
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h0; in_sel = 2'd0; out_ready = 4'h0;
    tick();
    tick();
    test_reset();
    test_routing();
    test_lane_full();
    test_simul_push_pop();
    test_head_of_line();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to4_stream.md
# demux1to4_stream

Registered 1-to-4 stream demultiplexer: the counterpart of the 4:1 byte mux tree on the return path. It routes each accepted input byte to one of four output lanes selected by a per-beat `in_sel`, with valid/ready handshakes on both sides. Each lane has its own small FIFO, so one stalled lane back-pressures the input only when that lane is targeted and full. It sits between a shared byte source and four independent consumers.

## Interface
- `WIDTH`, 8: data width per beat.
- `N_OUT`, 4: number of output lanes (power of two, ≥2).
- `DEPTH`, 2: entries per lane FIFO (power of two, ≥1).
- `CNT_W`, 16: width of per-lane delivered-beat counters.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-high reset (name kept for codebase consistency; asserted = 1).
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  WIDTH  input byte.
- `in_sel`  in  $clog2(N_OUT)  destination lane; sampled with `in_data`.
- `out_valid`  out  N_OUT  per-lane head entry valid.
- `out_ready`  in  N_OUT  per-lane consumer ready.
- `out_data`  out  N_OUT×WIDTH  packed `[N_OUT-1:0][WIDTH-1:0]`, per-lane head entry.
- `out_cnt`  out  N_OUT×CNT_W  packed, per-lane count of completed output handshakes.

## Operation
- Push: `in_valid && in_ready` writes `in_data` into lane `in_sel` FIFO. No other lane is affected.
- `in_ready = !rst_n_asserted && (count[in_sel] < DEPTH)`. It is combinational from `in_sel` and the lane count only. It does not depend on `out_ready`: a full lane refuses input even when it is popping in the same cycle.
- Pop: `out_valid[k] && out_ready[k]` removes lane k head. `out_cnt[k]` increments and wraps at 2^CNT_W to 0.
- `out_valid[k] = (count[k] != 0)`. `out_data[k]` = head entry, held stable while `out_valid[k] && !out_ready[k]`.
- Simultaneous push and pop on the same lane: both take effect and the count is unchanged. Order is preserved per lane.
- Pops on several lanes in one cycle are independent.
- Head-of-line: while the targeted lane is full, the input stalls, even when other lanes have space. `in_sel`/`in_data` must be held by the source while `in_valid && !in_ready`.
- Reset (`rst_n` = 1), regardless of in-flight traffic: on the next edge, all counts, pointers, `out_valid`, `out_data`, and `out_cnt` become 0. While reset is asserted, `in_ready` = 0. Pushes and pops in reset cycles are discarded.

## Timing
- Latency: a beat accepted at edge t is visible on `out_valid[k]`/`out_data[k]` after edge t (1 cycle). There is no combinational in→out data path.
- Throughput: 1 beat/cycle into any lane that is not full. A lane with DEPTH ≥ 2 sustains 1 beat/cycle under continuous `out_ready`. A lane with DEPTH = 1 sustains 1 beat per 2 cycles (documented limitation).
- Reset values: `in_ready` = 0 during reset, then 1 in the first cycle after release. `out_valid` = 0, `out_data` = 0, `out_cnt` = 0.
- Counter wrap: `out_cnt[k]` at 2^CNT_W−1 plus a pop gives 0 on the same edge.

## Structure
- Package `demux_pkg`: `SEL_W = $clog2(N_OUT)` helper, `typedef logic [WIDTH-1:0] beat_t` (WIDTH default 8), `lane_cnt_t`.
- Sub-module `demux_lane`: synchronous FIFO of DEPTH with `push`/`wdata`/`full`, `pop`/`rdata`/`empty`, wrap-around pointers plus an occupancy count, and the `out_cnt` counter. The top instantiates N_OUT lanes via `generate`. The top itself holds only the decode (`push[k] = in_valid && in_ready && in_sel==k`) and the `in_ready` mux.

## Test plan
- Reset: drive traffic, then assert `rst_n`=1 for 2 cycles with `in_valid`=1. Required: `in_ready`=0 throughout, then all `out_valid`=0, all `out_cnt`=0, and `in_ready`=1 in the cycle after release.
- Routing: send 0x11,0x22,0x33,0x44 with sel 0,1,2,3 and all `out_ready`=1. Required: each appears on its own lane exactly one cycle after acceptance, and each `out_cnt[k]`=1.
- Lane full: hold `out_ready[2]`=0 and send 3 beats to lane 2 (DEPTH=2). Required: the third beat sees `in_ready`=0. Then raise `out_ready[2]`. Required: 0xA0,0xA1 pop in order, and the third beat is accepted the cycle after the first pop.
- Simultaneous push/pop: lane 1 holds 1 entry. Push 0x5A to lane 1 while popping. Required: count stays 1, and the next head is 0x5A.
- Head-of-line: lane 0 is full, and input targets lane 0 and then lane 3. Required: the lane-3 beat is not accepted until lane 0 drains one entry.
- Wrap: with CNT_W=4, perform 17 pops on lane 3. Required: `out_cnt[3]` = 1.
